// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt-controller CPU receiver.
package intc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    PRESENT = 3'd2,
    SERVICE = 3'd3,
    CLEAR   = 3'd4,
    HOLDOFF = 3'd5
  } irq_rx_state_e;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_PULSE = 1'b1;
  localparam logic POL_LOW    = 1'b0;
  localparam logic POL_HIGH   = 1'b1;

endpackage

// File: rtl/intc_sat_counter.sv
// Saturating event counter; a clear request takes priority over an increment.
module intc_sat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count
);

  // count register: reset, then clear, then saturating increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CW{1'b1}})) begin
      count <= count + CW'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/intc_irq_receiver.sv
// CPU-side receiver: qualifies the controller's interrupt pin, waits for a stable
// vector, hands it to the core, and pulses the matching clear line after EOI.
module intc_irq_receiver
  import intc_pkg::*;
#(
  parameter int N        = 8,
  parameter int VW       = $clog2(N),
  parameter int STABLE   = 2,
  parameter int CLR_W    = 1,
  parameter int HOLD_MAX = 16,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          irq_in,
  input  logic [VW-1:0] irq_vector,
  input  logic          in_mode,
  input  logic          in_polarity,
  output logic          cpu_irq_valid,
  input  logic          cpu_irq_ready,
  output logic [VW-1:0] cpu_irq_id,
  input  logic          cpu_eoi,
  output logic [N-1:0]  int_clear,
  output logic          busy,
  output logic [CW-1:0] missed_cnt,
  output logic [CW-1:0] spurious_cnt,
  output logic          holdoff_err,
  input  logic          err_clr
);

  localparam int SW  = $clog2(STABLE + 1);
  localparam int CLW = $clog2(CLR_W + 1);
  localparam int HW  = $clog2(HOLD_MAX + 1);

  function automatic logic [N-1:0] onehot(input logic [VW-1:0] idx);
    return {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

  irq_rx_state_e  state, state_nx;
  logic           act, act_d, rise, trigger;
  logic [VW-1:0]  cand, cand_nx;
  logic [SW-1:0]  cnt, cnt_nx;
  logic [CLW-1:0] clr_cnt, clr_cnt_nx;
  logic [HW-1:0]  hold_cnt, hold_cnt_nx;
  logic           spurious_inc, missed_inc, hold_timeout;

  assign act        = (in_polarity == POL_HIGH) ? irq_in : ~irq_in;
  assign rise       = act & ~act_d;
  assign trigger    = (in_mode == MODE_PULSE) ? rise : act;
  assign missed_inc = (in_mode == MODE_PULSE) && rise && (state != IDLE);

  assign cpu_irq_valid = (state == PRESENT);
  assign cpu_irq_id    = cpu_irq_valid ? cand : '0;
  assign busy          = (state != IDLE);

  // state register, candidate vector, phase counters and registered clear pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      act_d       <= 1'b0;
      cand        <= '0;
      cnt         <= '0;
      clr_cnt     <= '0;
      hold_cnt    <= '0;
      int_clear   <= '0;
      holdoff_err <= 1'b0;
    end else begin
      state     <= state_nx;
      act_d     <= act;
      cand      <= cand_nx;
      cnt       <= cnt_nx;
      clr_cnt   <= clr_cnt_nx;
      hold_cnt  <= hold_cnt_nx;
      // The clear pulse lags CLEAR by one edge so the line is glitch-free.
      int_clear <= (state == CLEAR) ? onehot(cand) : '0;
      if (err_clr) begin
        holdoff_err <= 1'b0;
      end else if (hold_timeout) begin
        holdoff_err <= 1'b1;
      end else begin
        holdoff_err <= holdoff_err;
      end
    end
  end

  // next-state and datapath updates
  always_comb begin
    state_nx     = state;
    cand_nx      = cand;
    cnt_nx       = cnt;
    clr_cnt_nx   = clr_cnt;
    hold_cnt_nx  = hold_cnt;
    spurious_inc = 1'b0;
    hold_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          cand_nx  = irq_vector;
          cnt_nx   = SW'(1);
          state_nx = (STABLE == 1) ? PRESENT : CAPTURE;
        end else begin
          state_nx = IDLE;
        end
      end
      CAPTURE: begin
        if ((in_mode == MODE_LEVEL) && !act) begin
          spurious_inc = 1'b1;
          state_nx     = IDLE;
        end else if (irq_vector == cand) begin
          cnt_nx   = cnt + SW'(1);
          state_nx = (cnt == SW'(STABLE - 1)) ? PRESENT : CAPTURE;
        end else begin
          cand_nx  = irq_vector;
          cnt_nx   = SW'(1);
          state_nx = CAPTURE;
        end
      end
      PRESENT: begin
        if (cpu_irq_ready) begin
          state_nx = SERVICE;
        end else begin
          state_nx = PRESENT;
        end
      end
      SERVICE: begin
        if (cpu_eoi) begin
          clr_cnt_nx = '0;
          state_nx   = CLEAR;
        end else begin
          state_nx = SERVICE;
        end
      end
      CLEAR: begin
        if (clr_cnt == CLW'(CLR_W - 1)) begin
          hold_cnt_nx = '0;
          state_nx    = (in_mode == MODE_LEVEL) ? HOLDOFF : IDLE;
        end else begin
          clr_cnt_nx = clr_cnt + CLW'(1);
          state_nx   = CLEAR;
        end
      end
      HOLDOFF: begin
        // Wait for the controller to drop or move on before re-arming.
        if (!act || (irq_vector != cand)) begin
          state_nx = IDLE;
        end else if (hold_cnt == HW'(HOLD_MAX - 1)) begin
          hold_timeout = 1'b1;
          state_nx     = IDLE;
        end else begin
          hold_cnt_nx = hold_cnt + HW'(1);
          state_nx    = HOLDOFF;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  intc_sat_counter #(.CW(CW)) u_missed (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (missed_inc),
    .clr   (err_clr),
    .count (missed_cnt)
  );

  intc_sat_counter #(.CW(CW)) u_spurious (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (spurious_inc),
    .clr   (err_clr),
    .count (spurious_cnt)
  );

endmodule

// File: tb/tb_intc_irq_receiver.sv
// Self-checking bench for intc_irq_receiver: directed scenarios plus randomized
// traffic, compared every cycle against a phase/countdown reference model.
module tb_intc_irq_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       irq_in;
  logic [2:0] irq_vector;
  logic       in_mode;
  logic       in_polarity;
  logic       cpu_irq_valid;
  logic       cpu_irq_ready;
  logic [2:0] cpu_irq_id;
  logic       cpu_eoi;
  logic [7:0] int_clear;
  logic       busy;
  logic [7:0] missed_cnt;
  logic [7:0] spurious_cnt;
  logic       holdoff_err;
  logic       err_clr;

  int n_checks = 0;
  int n_errors = 0;

  // model: phase 0 idle, 1 settling, 2 offered, 3 in service, 4 clearing, 5 holding
  int         m_phase, m_cand, m_need, m_clr_left, m_hold_left;
  int         m_missed, m_spur;
  bit         m_herr, m_prev;
  logic [7:0] m_clear;

  intc_irq_receiver #(
    .N(8), .VW(3), .STABLE(2), .CLR_W(1), .HOLD_MAX(16), .CW(8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .irq_in        (irq_in),
    .irq_vector    (irq_vector),
    .in_mode       (in_mode),
    .in_polarity   (in_polarity),
    .cpu_irq_valid (cpu_irq_valid),
    .cpu_irq_ready (cpu_irq_ready),
    .cpu_irq_id    (cpu_irq_id),
    .cpu_eoi       (cpu_eoi),
    .int_clear     (int_clear),
    .busy          (busy),
    .missed_cnt    (missed_cnt),
    .spurious_cnt  (spurious_cnt),
    .holdoff_err   (holdoff_err),
    .err_clr       (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cand = 0; m_need = 0; m_clr_left = 0; m_hold_left = 0;
    m_missed = 0; m_spur = 0; m_herr = 1'b0; m_prev = 1'b0; m_clear = 8'd0;
  endtask

  task automatic model_step();
    bit a, edge_seen, spur_ev, tmo_ev;
    if (!rst_n) begin
      model_reset();
      return;
    end
    a = in_polarity ? irq_in : ~irq_in;
    edge_seen = a && !m_prev;
    spur_ev = 1'b0;
    tmo_ev  = 1'b0;
    m_clear = (m_phase == 4) ? (8'd1 << m_cand) : 8'd0;
    if (err_clr) m_missed = 0;
    else if (in_mode && edge_seen && m_phase != 0) m_missed = sat_inc(m_missed);
    case (m_phase)
      0: if (in_mode ? edge_seen : a) begin
           m_cand = int'(irq_vector);
           m_need = 1;
           m_phase = 1;
         end
      1: if (!in_mode && !a) begin
           spur_ev = 1'b1;
           m_phase = 0;
         end else if (int'(irq_vector) == m_cand) begin
           m_need--;
           if (m_need == 0) m_phase = 2;
         end else begin
           m_cand = int'(irq_vector);
           m_need = 1;
         end
      2: if (cpu_irq_ready) m_phase = 3;
      3: if (cpu_eoi) begin m_phase = 4; m_clr_left = 1; end
      4: begin
           m_clr_left--;
           if (m_clr_left == 0) begin
             m_phase = in_mode ? 0 : 5;
             m_hold_left = 16;
           end
         end
      5: if (!a || int'(irq_vector) != m_cand) m_phase = 0;
         else begin
           m_hold_left--;
           if (m_hold_left == 0) begin tmo_ev = 1'b1; m_phase = 0; end
         end
      default: m_phase = 0;
    endcase
    if (err_clr) begin m_spur = 0; m_herr = 1'b0; end
    else begin
      if (spur_ev) m_spur = sat_inc(m_spur);
      if (tmo_ev) m_herr = 1'b1;
    end
    m_prev = a;
  endtask

  task automatic compare_all();
    check("valid", cpu_irq_valid, (m_phase == 2));
    check("id", cpu_irq_id, (m_phase == 2) ? m_cand : 0);
    check("int_clear", int_clear, m_clear);
    check("busy", busy, (m_phase != 0));
    check("missed_cnt", missed_cnt, m_missed);
    check("spurious_cnt", spurious_cnt, m_spur);
    check("holdoff_err", holdoff_err, m_herr);
  endtask

  task automatic cycle(input logic i_irq, input logic [2:0] i_vec, input logic i_rdy,
                       input logic i_eoi, input logic i_eclr);
    irq_in = i_irq; irq_vector = i_vec; cpu_irq_ready = i_rdy;
    cpu_eoi = i_eoi; err_clr = i_eclr;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    bit pin;
    logic [2:0] vec;
    model_reset();
    rst_n = 1'b0; irq_in = 1'b0; irq_vector = 3'd0; in_mode = 1'b0; in_polarity = 1'b1;
    cpu_irq_ready = 1'b0; cpu_eoi = 1'b0; err_clr = 1'b0;
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    check("reset_valid", cpu_irq_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_clear", int_clear, 8'd0);
    rst_n = 1'b1;
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // level, active-high, vector 5
    cycle(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    check("lvl_not_yet_valid", cpu_irq_valid, 1'b0);
    cycle(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    check("lvl_valid", cpu_irq_valid, 1'b1);
    check("lvl_id", cpu_irq_id, 3'd5);
    cycle(1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
    check("lvl_valid_fall", cpu_irq_valid, 1'b0);
    cycle(1'b1, 3'd5, 1'b0, 1'b1, 1'b0);
    check("lvl_clear_wait", int_clear, 8'd0);
    cycle(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    check("lvl_clear", int_clear, 8'b0010_0000);
    cycle(1'b0, 3'd5, 1'b0, 1'b0, 1'b0);
    check("lvl_clear_end", int_clear, 8'd0);
    check("lvl_idle", busy, 1'b0);

    // vector glitch: 3 then 6
    cycle(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    check("glitch_not_valid", cpu_irq_valid, 1'b0);
    cycle(1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    check("glitch_valid", cpu_irq_valid, 1'b1);
    check("glitch_id", cpu_irq_id, 3'd6);
    cycle(1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 3'd6, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 3'd6, 1'b0, 1'b0, 1'b0);
    check("glitch_clear", int_clear, 8'b0100_0000);
    cycle(1'b0, 3'd6, 1'b0, 1'b0, 1'b0);

    // level drop during capture
    cycle(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    check("spur_cnt", spurious_cnt, 8'd1);
    check("spur_no_valid", cpu_irq_valid, 1'b0);
    cycle(1'b0, 3'd2, 1'b0, 1'b0, 1'b1);
    check("spur_cleared", spurious_cnt, 8'd0);

    // pulse mode, active-low
    in_mode = 1'b1; in_polarity = 1'b0;
    cycle(1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 3'd4, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    check("pulse_valid", cpu_irq_valid, 1'b1);
    check("pulse_id", cpu_irq_id, 3'd4);
    cycle(1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 3'd4, 1'b0, 1'b0, 1'b0);
    check("missed_one", missed_cnt, 8'd1);
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 3'd4, 1'b0, 1'b0, 1'b0);
    end
    check("missed_sat", missed_cnt, 8'd255);
    cycle(1'b1, 3'd4, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    check("pulse_clear", int_clear, 8'b0001_0000);
    check("pulse_idle", busy, 1'b0);
    cycle(1'b1, 3'd4, 1'b0, 1'b0, 1'b1);
    check("missed_cleared", missed_cnt, 8'd0);

    // holdoff timeout in level mode
    in_mode = 1'b0; in_polarity = 1'b1;
    cycle(1'b0, 3'd7, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 3'd7, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    check("holdoff_pending", holdoff_err, 1'b0);
    cycle(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    check("holdoff_err", holdoff_err, 1'b1);
    check("holdoff_idle", busy, 1'b0);
    cycle(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    check("retrigger_valid", cpu_irq_valid, 1'b1);

    // reset while presenting
    rst_n = 1'b0;
    cycle(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    check("rst_valid", cpu_irq_valid, 1'b0);
    check("rst_clear", int_clear, 8'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_herr", holdoff_err, 1'b0);
    rst_n = 1'b1;
    cycle(1'b0, 3'd7, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 3'd7, 1'b0, 1'b0, 1'b0);

    // randomized traffic over all mode/polarity combinations
    pin = 1'b0;
    vec = 3'd0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 40 && m_phase != 0; i++)
        cycle(irq_in, irq_vector, 1'b1, 1'b1, 1'b0);
      if (m_phase == 0) begin
        in_mode = k[0];
        in_polarity = k[1];
      end
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 3) == 0) pin = ~pin;
        if ($urandom_range(0, 5) == 0) vec = 3'($urandom_range(0, 7));
        cycle(pin, vec, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 40) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
